store_buffer_fwd: RTL and testbench

Parametrised, coalescing store buffer between the load/store commit stage and the data-memory port. It accepts committed stores into a circular FIFO and merges a new store into the youngest waiting entry when both target the same word. It drains entries to memory one at a time with a request/response handshake, and gives loads combinational byte-granular store-to-load forwarding. Loads that only partially overlap buffered data are stalled.

---
 rtl/store_buffer_fwd.sv | 192 +++++++++++++++++++
 tb/tb_store_buffer_fwd.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_fwd.sv
// Coalescing store buffer: circular FIFO of committed stores, merge into the
// youngest waiting entry, one-at-a-time drain to memory, byte-granular
// store-to-load forwarding with partial-overlap stall.
module store_buffer_fwd #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_wdata,
    input  logic [DATA_W/8-1:0]        st_wmask,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic [DATA_W/8-1:0]        ld_rmask,
    output logic                       ld_fwd_hit,
    output logic [DATA_W-1:0]          ld_fwd_data,
    output logic                       ld_fwd_stall,
    input  logic                       mem_grant,
    output logic [ADDR_W-1:0]          dmem_addr,
    output logic [DATA_W/8-1:0]        dmem_wmask,
    output logic [DATA_W-1:0]          dmem_wdata,
    output logic [DATA_W/8-1:0]        dmem_rmask,
    input  logic                       dmem_resp,
    output logic                       sb_full,
    output logic                       sb_empty,
    output logic [$clog2(DEPTH):0]     sb_count
);

    localparam int unsigned M  = DATA_W / 8;
    localparam int unsigned O  = $clog2(M);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned WA = ADDR_W - O;
    localparam logic [PW:0] FullCnt = (PW+1)'(DEPTH);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e            state_q, state_d;
    logic [DEPTH-1:0]  valid_q;
    logic [WA-1:0]     waddr_q [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [M-1:0]      mask_q  [DEPTH];
    logic [PW-1:0]     head_q, tail_q;
    logic [PW:0]       count_q, count_d;
    logic [ADDR_W-1:0] dmem_addr_q;
    logic [M-1:0]      dmem_wmask_q;
    logic [DATA_W-1:0] dmem_wdata_q;

    logic [PW-1:0]     youngest;
    logic [WA-1:0]     st_word, ld_word;
    logic              merge_ok, st_acc, push, do_merge, pop, latch;
    logic [DATA_W-1:0] merged_data, head_data;
    logic [M-1:0]      merged_mask, head_mask;
    logic [M-1:0]      covered;
    logic [DATA_W-1:0] fwd_raw;
    logic [PW-1:0]     idx;
    logic              st_overlap;
    logic              unused_low_bits;

    assign unused_low_bits = ^{st_addr[O-1:0], ld_addr[O-1:0]};

    assign sb_full    = (count_q == FullCnt);
    assign sb_empty   = (count_q == '0);
    assign sb_count   = count_q;
    assign st_ready   = ~sb_full;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_wmask = (state_q == StReq) ? dmem_wmask_q : '0;
    assign dmem_rmask = '0;

    // Store acceptance: merge into youngest entry unless it is the in-flight head.
    always_comb begin
        youngest = tail_q - PW'(1);
        st_word  = st_addr[ADDR_W-1:O];
        merge_ok = !sb_empty && valid_q[youngest] && (waddr_q[youngest] == st_word) &&
                   !((state_q == StReq) && (youngest == head_q));
        st_acc   = st_valid && st_ready;
        push     = st_acc && !merge_ok;
        do_merge = st_acc && merge_ok;
        pop      = (state_q == StReq) && dmem_resp;
        count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        for (int b = 0; b < M; b++) begin
            merged_data[8*b +: 8] = st_wmask[b] ? st_wdata[8*b +: 8] : data_q[youngest][8*b +: 8];
        end
        merged_mask = mask_q[youngest] | st_wmask;
        // A merge into the head in the latch cycle must reach memory too.
        if (do_merge && (youngest == head_q)) begin
            head_data = merged_data;
            head_mask = merged_mask;
        end else begin
            head_data = data_q[head_q];
            head_mask = mask_q[head_q];
        end
    end

    // Entry array, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
                data_q[i]  <= '0;
                mask_q[i]  <= '0;
            end
        end else begin
            if (do_merge) begin
                data_q[youngest] <= merged_data;
                mask_q[youngest] <= merged_mask;
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                waddr_q[tail_q] <= st_word;
                data_q[tail_q]  <= st_wdata;
                mask_q[tail_q]  <= st_wmask;
                tail_q          <= tail_q + PW'(1);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Drain FSM next state.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!sb_empty && mem_grant) begin
                    state_d = StReq;
                    latch   = 1'b1;
                end
            end
            StReq: begin
                if (dmem_resp) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Drain state and held memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            dmem_addr_q  <= '0;
            dmem_wmask_q <= '0;
            dmem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                dmem_addr_q  <= ADDR_W'(waddr_q[head_q]) << O;
                dmem_wmask_q <= head_mask;
                dmem_wdata_q <= head_data;
            end
        end
    end

    // Forwarding: walk oldest to youngest so younger matches override per lane.
    always_comb begin
        ld_word = ld_addr[ADDR_W-1:O];
        covered = '0;
        fwd_raw = '0;
        idx     = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (waddr_q[idx] == ld_word)) begin
                for (int b = 0; b < M; b++) begin
                    if (mask_q[idx][b]) begin
                        covered[b]        = 1'b1;
                        fwd_raw[8*b +: 8] = data_q[idx][8*b +: 8];
                    end
                end
            end
        end
        covered    = covered & ld_rmask;
        st_overlap = st_valid && (st_word == ld_word) && ((st_wmask & ld_rmask) != '0);
        ld_fwd_stall = ld_valid && (((covered != '0) && (covered != ld_rmask)) || st_overlap);
        ld_fwd_hit   = ld_valid && !ld_fwd_stall && (ld_rmask != '0) && (covered == ld_rmask);
        for (int b = 0; b < M; b++) begin
            ld_fwd_data[8*b +: 8] = (ld_valid && ld_rmask[b]) ? fwd_raw[8*b +: 8] : 8'h00;
        end
    end

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Scoreboard bench for store_buffer_fwd: expected memory writes are queued as
// stores are issued and checked when the drain request appears.
module tb_store_buffer_fwd;

    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_wdata = '0;
    logic [3:0]  st_wmask = '0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [3:0]  ld_rmask = '0;
    logic        ld_fwd_hit;
    logic [31:0] ld_fwd_data;
    logic        ld_fwd_stall;
    logic        mem_grant = 1'b0;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_rmask;
    logic        dmem_resp = 1'b0;
    logic        sb_full;
    logic        sb_empty;
    logic [3:0]  sb_count;

    int total = 0;
    int bad   = 0;
    wr_t exp_q[$];
    int  resp_delay = 1;
    bit  resp_force = 1'b0;
    bit  in_req = 1'b0;
    int  cyc = 0;
    wr_t cur;

    store_buffer_fwd #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wdata(st_wdata), .st_wmask(st_wmask),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_rmask(ld_rmask),
        .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data), .ld_fwd_stall(ld_fwd_stall),
        .mem_grant(mem_grant), .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rmask(dmem_rmask), .dmem_resp(dmem_resp),
        .sb_full(sb_full), .sb_empty(sb_empty), .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lanes(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Memory model: check each new request against the scoreboard, check it
    // stays stable while outstanding, and answer after resp_delay cycles.
    always @(negedge clk) begin
        if (dmem_wmask != 4'h0) begin
            if (!in_req) begin
                in_req = 1'b1;
                cyc    = 0;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got addr=%h mask=%h data=%h, want none",
                             dmem_addr, dmem_wmask, dmem_wdata);
                end else begin
                    cur = exp_q.pop_front();
                    if (dmem_addr !== cur.addr || dmem_wmask !== cur.mask ||
                        (dmem_wdata & lanes(cur.mask)) !== (cur.data & lanes(cur.mask))) begin
                        bad++;
                        $display("FAIL write: got addr=%h mask=%h data=%h, want addr=%h mask=%h data=%h",
                                 dmem_addr, dmem_wmask, dmem_wdata, cur.addr, cur.mask, cur.data);
                    end
                end
                total++;
                if (dmem_rmask !== 4'h0) begin
                    bad++;
                    $display("FAIL rmask: got %h want 0", dmem_rmask);
                end
                cur.data = dmem_wdata;
            end else begin
                total++;
                if (dmem_addr !== cur.addr || dmem_wmask !== cur.mask || dmem_wdata !== cur.data) begin
                    bad++;
                    $display("FAIL req_stable: got addr=%h mask=%h data=%h, want addr=%h mask=%h data=%h",
                             dmem_addr, dmem_wmask, dmem_wdata, cur.addr, cur.mask, cur.data);
                end
            end
            dmem_resp = (cyc == resp_delay) || resp_force;
            cyc++;
        end else begin
            in_req    = 1'b0;
            dmem_resp = resp_force;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        st_valid = 1'b1; st_addr = a; st_wmask = m; st_wdata = d;
        step();
        st_valid = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.mask = m; w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300; i++) begin
            if (sb_empty && dmem_wmask == 4'h0) break;
            step();
        end
        total++;
        if (!(sb_empty === 1'b1 && sb_count === 4'd0 && dmem_wmask === 4'h0)) begin
            bad++;
            $display("FAIL drain_timeout: got empty=%b count=%0d, want empty=1 count=0",
                     sb_empty, sb_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ld_valid = 1'b1; ld_addr = 32'h100; ld_rmask = 4'hF;
        step(); step();
        total++;
        if ({sb_empty, sb_full, st_ready, sb_count} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL reset_status: got empty=%b full=%b ready=%b count=%0d, want 1 0 1 0",
                     sb_empty, sb_full, st_ready, sb_count);
        end
        total++;
        if ({dmem_addr, dmem_wmask, dmem_wdata, dmem_rmask} !== 72'h0) begin
            bad++;
            $display("FAIL reset_dmem: got addr=%h mask=%h data=%h, want 0", dmem_addr,
                     dmem_wmask, dmem_wdata);
        end
        total++;
        if ({ld_fwd_hit, ld_fwd_stall, ld_fwd_data} !== 34'h0) begin
            bad++;
            $display("FAIL reset_fwd: got hit=%b stall=%b data=%h, want 0", ld_fwd_hit,
                     ld_fwd_stall, ld_fwd_data);
        end
        ld_valid = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_drain();
        mem_grant = 1'b1; resp_delay = 1;
        expect_wr(32'h100, 4'hF, 32'h11223344);
        expect_wr(32'h200, 4'h3, 32'h00005566);
        do_store(32'h100, 4'hF, 32'h11223344);
        do_store(32'h200, 4'h3, 32'h00005566);
        wait_empty();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_pending: got %0d writes outstanding, want 0", exp_q.size());
        end
        mem_grant = 1'b0;
    endtask

    task automatic test_merge();
        mem_grant = 1'b0;
        do_store(32'h104, 4'h1, 32'h000000AA);
        do_store(32'h105, 4'h2, 32'h0000BB00);
        total++;
        if (sb_count !== 4'd1) begin
            bad++;
            $display("FAIL merge_count: got %0d want 1", sb_count);
        end
        expect_wr(32'h104, 4'h3, 32'h0000BBAA);
        mem_grant = 1'b1;
        wait_empty();
        mem_grant = 1'b0;
    endtask

    task automatic test_forward();
        mem_grant = 1'b0;
        do_store(32'h300, 4'hF, 32'hDEADBEEF);
        ld_valid = 1'b1; ld_addr = 32'h302; ld_rmask = 4'hC; #1;
        total++;
        if ({ld_fwd_hit, ld_fwd_stall, ld_fwd_data} !== {2'b10, 32'hDEAD0000}) begin
            bad++;
            $display("FAIL fwd_upper: got hit=%b stall=%b data=%h, want 1 0 dead0000",
                     ld_fwd_hit, ld_fwd_stall, ld_fwd_data);
        end
        ld_addr = 32'h400; ld_rmask = 4'hF; #1;
        total++;
        if ({ld_fwd_hit, ld_fwd_stall} !== 2'b00) begin
            bad++;
            $display("FAIL fwd_miss: got hit=%b stall=%b, want 0 0", ld_fwd_hit, ld_fwd_stall);
        end
        ld_valid = 1'b0;
        expect_wr(32'h300, 4'hF, 32'hDEADBEEF);
        mem_grant = 1'b1; wait_empty(); mem_grant = 1'b0;

        do_store(32'h300, 4'h3, 32'h00001234);
        ld_valid = 1'b1; ld_addr = 32'h300; ld_rmask = 4'hF; #1;
        total++;
        if ({ld_fwd_hit, ld_fwd_stall} !== 2'b01) begin
            bad++;
            $display("FAIL fwd_partial: got hit=%b stall=%b, want 0 1", ld_fwd_hit, ld_fwd_stall);
        end
        // Store in the same cycle as the load is not searchable yet.
        st_valid = 1'b1; st_addr = 32'h500; st_wmask = 4'h1; st_wdata = 32'h77;
        ld_addr = 32'h500; ld_rmask = 4'h1; #1;
        total++;
        if ({ld_fwd_hit, ld_fwd_stall} !== 2'b01) begin
            bad++;
            $display("FAIL fwd_incoming: got hit=%b stall=%b, want 0 1", ld_fwd_hit, ld_fwd_stall);
        end
        st_valid = 1'b0; ld_valid = 1'b0;
        expect_wr(32'h300, 4'h3, 32'h00001234);
        mem_grant = 1'b1; wait_empty(); mem_grant = 1'b0;

        do_store(32'h600, 4'hF, 32'h11111111);
        do_store(32'h700, 4'hF, 32'h99999999);
        do_store(32'h600, 4'h1, 32'h00000022);
        ld_valid = 1'b1; ld_addr = 32'h600; ld_rmask = 4'hF; #1;
        total++;
        if ({ld_fwd_hit, ld_fwd_stall, ld_fwd_data, sb_count} !== {2'b10, 32'h11111122, 4'd3}) begin
            bad++;
            $display("FAIL fwd_youngest: got hit=%b stall=%b data=%h count=%0d, want 1 0 11111122 3",
                     ld_fwd_hit, ld_fwd_stall, ld_fwd_data, sb_count);
        end
        ld_valid = 1'b0;
        expect_wr(32'h600, 4'hF, 32'h11111111);
        expect_wr(32'h700, 4'hF, 32'h99999999);
        expect_wr(32'h600, 4'h1, 32'h00000022);
        mem_grant = 1'b1; wait_empty(); mem_grant = 1'b0;
    endtask

    task automatic test_full();
        bit seen;
        mem_grant = 1'b0; resp_delay = 1;
        for (int i = 0; i < DEPTH; i++) begin
            expect_wr(32'h800 + 4 * i, 4'hF, 32'h01010101 * i);
            do_store(32'h800 + 4 * i, 4'hF, 32'h01010101 * i);
        end
        total++;
        if ({sb_full, st_ready, sb_count} !== {1'b1, 1'b0, 4'd8}) begin
            bad++;
            $display("FAIL full_status: got full=%b ready=%b count=%0d, want 1 0 8",
                     sb_full, st_ready, sb_count);
        end
        do_store(32'h81C, 4'hF, 32'hFFFFFFFF);
        ld_valid = 1'b1; ld_addr = 32'h81C; ld_rmask = 4'hF; #1;
        total++;
        if ({sb_count, ld_fwd_hit, ld_fwd_data} !== {4'd8, 1'b1, 32'h07070707}) begin
            bad++;
            $display("FAIL full_reject: got count=%0d hit=%b data=%h, want 8 1 07070707",
                     sb_count, ld_fwd_hit, ld_fwd_data);
        end
        ld_valid = 1'b0;
        mem_grant = 1'b1; step(); mem_grant = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sb_count != 4'd8) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        total++;
        if (!(seen && sb_count === 4'd7 && st_ready === 1'b1)) begin
            bad++;
            $display("FAIL full_pop_ready: got count=%0d ready=%b, want 7 1", sb_count, st_ready);
        end
        mem_grant = 1'b1; wait_empty(); mem_grant = 1'b0;
    endtask

    task automatic test_inflight();
        mem_grant = 1'b1; resp_delay = 5;
        expect_wr(32'h400, 4'hF, 32'hCAFEF00D);
        expect_wr(32'h400, 4'hF, 32'h12345678);
        do_store(32'h400, 4'hF, 32'hCAFEF00D);
        step();
        mem_grant = 1'b0;
        do_store(32'h400, 4'hF, 32'h12345678);
        ld_valid = 1'b1; ld_addr = 32'h400; ld_rmask = 4'hF; #1;
        total++;
        if ({sb_count, dmem_addr, dmem_wmask, dmem_wdata} !== {4'd2, 32'h400, 4'hF, 32'hCAFEF00D}) begin
            bad++;
            $display("FAIL inflight_alloc: got count=%0d addr=%h mask=%h data=%h, want 2 400 f cafef00d",
                     sb_count, dmem_addr, dmem_wmask, dmem_wdata);
        end
        total++;
        if ({ld_fwd_hit, ld_fwd_data} !== {1'b1, 32'h12345678}) begin
            bad++;
            $display("FAIL inflight_fwd: got hit=%b data=%h, want 1 12345678", ld_fwd_hit, ld_fwd_data);
        end
        ld_valid = 1'b0;
        mem_grant = 1'b1; wait_empty(); mem_grant = 1'b0;
        resp_delay = 1;
    endtask

    task automatic test_reset_req();
        bit seen;
        mem_grant = 1'b1; resp_delay = 1000;
        expect_wr(32'h900, 4'hF, 32'hA5A5A5A5);
        do_store(32'h900, 4'hF, 32'hA5A5A5A5);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dmem_wmask != 4'h0) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        mem_grant = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (!seen || {dmem_addr, dmem_wmask, dmem_wdata, sb_count, sb_empty, sb_full, st_ready} !==
                     {32'h0, 4'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_in_req: got seen=%b addr=%h mask=%h data=%h count=%0d empty=%b",
                     seen, dmem_addr, dmem_wmask, dmem_wdata, sb_count, sb_empty);
        end
        do_store(32'hA00, 4'hF, 32'h5A5A5A5A);
        resp_force = 1'b1;
        step(); step();
        resp_force = 1'b0;
        total++;
        if (sb_count !== 4'd1) begin
            bad++;
            $display("FAIL stale_resp: got count=%0d want 1", sb_count);
        end
        resp_delay = 1;
        expect_wr(32'hA00, 4'hF, 32'h5A5A5A5A);
        mem_grant = 1'b1; wait_empty(); mem_grant = 1'b0;
    endtask

    initial begin
        test_reset();
        test_drain();
        test_merge();
        test_forward();
        test_full();
        test_inflight();
        test_reset_req();
        step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_pending: got %0d writes outstanding, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
